tilt_motion_ctrl: RTL
=====================

// Module: tilt_motion_ctrl
// PURPOSE
//  Parametrised accelerometer-to-sprite motion controller; successor to the fixed +/-5 px stepper.
//  Converts signed X/Y tilt samples from spi_control into clamped sprite coordinates.
//  Motion uses a dead zone, proportional target speed and per-sample velocity ramping (ACCEL).
//  Sits between the accelerometer sampling path and the sprite/TripleDigitDisplay consumers.
// PARAMETERS
//  DATAW      16   width of signed tilt samples (two's complement)
//  CORDW      16   width of screen coordinates (unsigned)
//  VELW       6    width of signed velocity registers
//  X_MIN/X_MAX  0/600  inclusive sprite_x clamp range
//  Y_MIN/Y_MAX  0/441  inclusive sprite_y clamp range
//  X_INIT/Y_INIT 300/240  reset position
//  DEADZONE   64   |tilt| <= DEADZONE gives target speed 0
//  SHIFT      5    target speed = ((|tilt|-DEADZONE) >> SHIFT) + 1
//  MAX_SPEED  8    target-speed ceiling, px/update; must be < 2**(VELW-1)
//  ACCEL      1    max change of velocity per update
//  INVERT_Y   1    1: positive Y tilt moves sprite up (y decreases)
// PORTS
//  slowclk      in   1      update clock (accelerometer-rate)
//  reset_n      in   1      synchronous, active-low reset
//  sample_valid in   1      1-cycle strobe; data_x/data_y valid this cycle
//  data_x       in   DATAW  signed X tilt
//  data_y       in   DATAW  signed Y tilt
//  freeze       in   1      hold position, discard samples
//  pos_x        out  CORDW  sprite x (registered)
//  pos_y        out  CORDW  sprite y (registered)
//  moving_x/y   out  1      velocity on that axis != 0
//  edge_x/y     out  1      last update clamped that axis
//  update_done  out  1      1-cycle pulse, position updated from a sample
// BEHAVIOUR
//  Reset is synchronous: reset_n=0 at a slowclk edge gives pos=INIT, vel=0, edge=0, moving=0,
//   update_done=0, state IDLE; it overrides every other input, including mid-update.
//  States: IDLE (after reset, no sample yet), RUN, FROZEN.
//   IDLE: sample_valid & ~freeze -> process sample, go RUN; freeze -> FROZEN.
//   RUN:  freeze -> FROZEN (takes priority over a same-cycle sample_valid, which is dropped).
//   FROZEN: vel forced 0, pos held, samples ignored; ~freeze -> RUN (next sample is processed).
//  Per axis, on a processed sample (outputs valid on the next edge, latency 1):
//   mag = |tilt|, with -2**(DATAW-1) saturating to 2**(DATAW-1)-1.
//   tgt = 0 if mag<=DEADZONE, else min(MAX_SPEED, ((mag-DEADZONE)>>SHIFT)+1), sign = sign(tilt);
//    Y sign negated when INVERT_Y=1.
//   vel' = vel moved toward tgt by at most ACCEL, without overshoot (covers decay to 0 in dead zone).
//   p = pos + vel', computed signed at CORDW+1 bits; result clamped to [MIN,MAX].
//    When clamped: pos=bound, vel'=0, edge=1; otherwise edge=0.
//  Both axes update in the same cycle; update_done pulses with them. No sample -> all held,
//   update_done=0. moving_x/y reflect the registered velocity.
//  Out-of-range INIT is invalid (parameter assertion) and is not clamped.
// STRUCTURE
//  motion_pkg: motion_state_e {IDLE,RUN,FROZEN}; shared clamp/saturate functions.
//  tilt_axis sub-module, instantiated twice (X; Y with INVERT=INVERT_Y): mag/target/ramp/clamp,
//   holds pos/vel/edge; top holds the FSM and update_done.
// TESTING
//  Reset: hold reset_n=0 2 cycles -> pos=(300,240), moving=0, edge=0, update_done=0, state IDLE.
//  Ramp: data_x=+2000, 4 strobes -> tgt=8; vel 1,2,3,4; pos_x 301,303,306,310; update_done each.
//  Dead zone: with vel_x=4, data_x=40 for 5 strobes -> pos_x +3,+2,+1,+0,+0; moving_x=0 after 4th.
//  Clamp: pos_x=596, vel_x=8 strobe -> pos_x=600, edge_x=1, moving_x=0; Y at 0 with data_y=+2000 -> pos_y=0, edge_y=1.
//  Freeze: freeze=1 with a same-cycle strobe -> pos held, vel 0, no update_done; freeze=0 then strobe -> motion resumes at vel 1.
//  Extremes/reset: data_y=-32768 -> vel_y +1 (INVERT_Y); reset_n=0 mid-ramp -> back to INIT, state IDLE.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and arithmetic helpers for the tilt motion controller.
// Helpers work on 32-bit ints; callers sign- or zero-extend into them.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } motion_state_e;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // |v| saturated to maxpos, so the most negative sample maps to the top code
    function automatic int sat_abs(input int v, input int maxpos);
        int a;
        a = (v < 0) ? -v : v;
        return (a > maxpos) ? maxpos : a;
    endfunction

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo)
            return lo;
        if (v > hi)
            return hi;
        return v;
    endfunction

endpackage

// File: rtl/tilt_axis.sv
// One motion axis: tilt magnitude -> target speed -> ramped velocity
// -> clamped position. Holds this axis' position, velocity and edge flag.
module tilt_axis
    import motion_pkg::*;
#(
    parameter int DATAW     = 16,
    parameter int CORDW     = 16,
    parameter int VELW      = 6,
    parameter int MIN       = 0,
    parameter int MAX       = 600,
    parameter int INIT      = 300,
    parameter int DEADZONE  = 64,
    parameter int SHIFT     = 5,
    parameter int MAX_SPEED = 8,
    parameter int ACCEL     = 1,
    parameter bit INVERT    = 1'b0
) (
    input  logic                    slowclk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    hold,
    input  logic signed [DATAW-1:0] tilt,
    output logic [CORDW-1:0]        pos,
    output logic                    moving,
    output logic                    at_edge
);

    localparam int MAG_MAX = 2**(DATAW-1) - 1;

    if (INIT < MIN || INIT > MAX) begin : g_bad_init
        $error("tilt_axis: INIT outside [MIN,MAX]");
    end
    if (MAX_SPEED >= 2**(VELW-1)) begin : g_bad_speed
        $error("tilt_axis: MAX_SPEED does not fit in VELW");
    end
    if (DATAW > 31) begin : g_bad_dataw
        $error("tilt_axis: DATAW must be at most 31");
    end

    logic signed [VELW-1:0] vel;
    logic signed [CORDW:0]  psum;
    int                     mag;
    int                     spd;
    int                     tgt;
    int                     vcur;
    int                     vnext;
    int                     pnext;
    logic                   clamped;

    // Target speed, velocity ramp and clamped position for this sample
    always_comb begin
        mag = sat_abs(int'(tilt), MAG_MAX);
        spd = 0;
        if (mag > DEADZONE)
            spd = min_int(MAX_SPEED, ((mag - DEADZONE) >>> SHIFT) + 1);
        tgt = (tilt[DATAW-1] ^ INVERT) ? -spd : spd;
        vcur  = int'(vel);
        vnext = vcur;
        if (tgt > vcur)
            vnext = min_int(tgt, vcur + ACCEL);
        else if (tgt < vcur)
            vnext = max_int(tgt, vcur - ACCEL);
        psum    = $signed({1'b0, pos}) + (CORDW+1)'(vnext);
        pnext   = clamp_int(int'(psum), MIN, MAX);
        clamped = (pnext != int'(psum));
    end

    // Axis state: reset to INIT, zero velocity while frozen, update per sample
    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            pos     <= CORDW'(INIT);
            vel     <= '0;
            at_edge <= 1'b0;
        end else if (hold) begin
            vel <= '0;
        end else if (load) begin
            pos     <= CORDW'(pnext);
            vel     <= clamped ? '0 : VELW'(vnext);
            at_edge <= clamped;
        end
    end

    assign moving = (vel != '0);

endmodule

// File: rtl/tilt_motion_ctrl.sv
// Accelerometer-to-sprite motion controller: run/freeze FSM plus
// two tilt_axis instances updated together on each accepted sample.
module tilt_motion_ctrl
    import motion_pkg::*;
#(
    parameter int DATAW     = 16,
    parameter int CORDW     = 16,
    parameter int VELW      = 6,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 600,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 441,
    parameter int X_INIT    = 300,
    parameter int Y_INIT    = 240,
    parameter int DEADZONE  = 64,
    parameter int SHIFT     = 5,
    parameter int MAX_SPEED = 8,
    parameter int ACCEL     = 1,
    parameter bit INVERT_Y  = 1'b1
) (
    input  logic                    slowclk,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic signed [DATAW-1:0] data_x,
    input  logic signed [DATAW-1:0] data_y,
    input  logic                    freeze,
    output logic [CORDW-1:0]        pos_x,
    output logic [CORDW-1:0]        pos_y,
    output logic                    moving_x,
    output logic                    moving_y,
    output logic                    edge_x,
    output logic                    edge_y,
    output logic                    update_done
);

    motion_state_e state;
    motion_state_e state_next;
    logic          take;
    logic          hold;

    // State register
    always_ff @(posedge slowclk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: freeze wins over a same-cycle sample
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (freeze)
                    state_next = FROZEN;
                else if (sample_valid)
                    state_next = RUN;
            end
            RUN: begin
                if (freeze)
                    state_next = FROZEN;
            end
            FROZEN: begin
                if (!freeze)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: accept a sample only when not frozen; zero velocity on freeze
    always_comb begin
        take = 1'b0;
        hold = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                take = sample_valid & ~freeze;
                hold = freeze;
            end
            FROZEN: begin
                hold = 1'b1;
            end
            default: begin
                take = 1'b0;
                hold = 1'b0;
            end
        endcase
    end

    // One-cycle pulse aligned with the position update
    always_ff @(posedge slowclk) begin
        if (!reset_n)
            update_done <= 1'b0;
        else
            update_done <= take;
    end

    tilt_axis #(
        .DATAW(DATAW), .CORDW(CORDW), .VELW(VELW),
        .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT),
        .DEADZONE(DEADZONE), .SHIFT(SHIFT),
        .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL), .INVERT(1'b0)
    ) u_axis_x (
        .slowclk(slowclk),
        .reset_n(reset_n),
        .load(take),
        .hold(hold),
        .tilt(data_x),
        .pos(pos_x),
        .moving(moving_x),
        .at_edge(edge_x)
    );

    tilt_axis #(
        .DATAW(DATAW), .CORDW(CORDW), .VELW(VELW),
        .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT),
        .DEADZONE(DEADZONE), .SHIFT(SHIFT),
        .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL), .INVERT(INVERT_Y)
    ) u_axis_y (
        .slowclk(slowclk),
        .reset_n(reset_n),
        .load(take),
        .hold(hold),
        .tilt(data_y),
        .pos(pos_y),
        .moving(moving_y),
        .at_edge(edge_y)
    );

endmodule
